seq_matrix_multiplier: RTL and testbench
========================================

# seq_matrix_multiplier

Sequential, parametrised fixed-point matrix–vector multiplier: computes `vectorout = matrixin × vectorin` for a ROWS×COLS signed fixed-point matrix using one shared multiply-accumulate datapath, one product per clock. It is the clocked successor to the combinational matrix multiplier in the top level. It trades ROWS×COLS multipliers for one, and adds a start/busy/done handshake, round-half-up rescaling, and selectable saturate/wrap overflow handling with a sticky overflow flag.

## Interface
- `WIDTH`, 32, total bits per signed two's-complement element
- `FRAC`, 8, fractional bits; 0 ≤ FRAC < WIDTH
- `ROWS`, 2, matrix rows / output length; ≥ 1
- `COLS`, 2, matrix columns / input vector length; ≥ 1
- `SATURATE`, 1, 1 = clamp on overflow, 0 = wrap (keep low WIDTH bits)
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  request; accepted only in IDLE
- `vectorin[COLS]`  in  WIDTH each  input vector, sampled at the accepting edge
- `matrixin[ROWS][COLS]`  in  WIDTH each  matrix, row-major, sampled at the accepting edge
- `busy`  out  1  high while in MAC
- `done`  out  1  one-cycle pulse when results are valid
- `vectorout[ROWS]`  out  WIDTH each  result, held until the next completion
- `overflow`  out  1  sticky: any row of the last operation over/underflowed

## Operation
- FSM states: IDLE → MAC → DONE → IDLE.
  - IDLE + `start` = 1: latch `vectorin`/`matrixin` into internal registers. Clear the accumulator, row/col counters and the internal overflow flag. Go to MAC.
  - MAC: each edge, `acc <= acc + A[r][c]*x[c]`, then advance c. At c = COLS-1, finalise row r, reset the accumulator to 0, set c = 0, r++.
  - After row ROWS-1 finalises, go to DONE.
  - DONE: one cycle, then IDLE.
- `start` is ignored in MAC and DONE. No queuing.
- Arithmetic:
  - Product: 2·WIDTH bits, signed.
  - Accumulator: 2·WIDTH + clog2(COLS) bits, signed, never overflows.
  - Finalise: add 2^(FRAC-1) when FRAC > 0 (round half up, toward +∞), arithmetic shift right by FRAC, then reduce to WIDTH bits.
  - Out of range, SATURATE = 1: clamp to 2^(WIDTH-1)-1 or -2^(WIDTH-1).
  - Out of range, SATURATE = 0: take the low WIDTH bits.
  - Either mode: set the internal overflow flag when out of range.
- Rows 0..ROWS-2 finalise into staging registers. At the final MAC edge, all of `vectorout` updates together (staging plus the last row), and `overflow` takes the internal flag.
- Outputs change only at completion or reset. Internal registers are never visible mid-operation.

## Timing
- Reset (asynchronous, any state): state = IDLE; `busy`, `done`, `overflow` = 0; every `vectorout` element = 0; counters, accumulator and staging = 0.
- A reset in mid-operation aborts it: no `done` pulse, and outputs stay 0.
- Let E0 be the edge that samples `start` = 1 in IDLE:
  - `busy` = 1 from after E0 through edge E(ROWS·COLS).
  - MAC occupies edges E1..E(ROWS·COLS).
  - `vectorout` and `overflow` update at E(ROWS·COLS).
  - `done` = 1 and `busy` = 0 during the cycle between E(ROWS·COLS) and E(ROWS·COLS+1).
- Latency from the accepting edge to `done`: ROWS·COLS cycles.
- With `start` held high, operations repeat every ROWS·COLS+2 cycles.
- Inputs may change freely after E0.

## Structure
- Shared package `matmul_pkg`:
  - FSM state enum (IDLE, MAC, DONE).
  - Accumulator-width function.
  - Rounding/saturation function `fx_round_sat` (returns value and overflow bit).
- Sub-module `fx_mac_unit`: signed multiply-accumulate with clear, accumulate enable and a finalise output (round, shift, saturate/wrap, overflow), parametrised by WIDTH, FRAC, COLS and SATURATE.
- Top: FSM, counters, input latches, staging and output registers.

## Test plan
All scenarios use default parameters (Q24.8, 1.0 = 256) unless stated.
1. Identity: matrix [[256,0],[0,256]], vector [768,-512], `start` pulse → `done` exactly 4 cycles after E0, `vectorout` = [768,-512], `overflow` = 0, `busy` high for 4 cycles.
2. Rounding: matrix [[128,0],[-128,0]], vector [1,0] → `vectorout` = [1,0] (+0.5 LSB rounds up; -0.5 LSB rounds to 0).
3. Saturation:
   - SATURATE = 1: matrix [[0x40000000,0x40000000],[0xC0000000,0xC0000000]], vector [0x00010000,0x00010000] → `vectorout` = [0x7FFFFFFF,0x80000000], `overflow` = 1.
   - SATURATE = 0, same stimulus → `vectorout` = [0,0], `overflow` = 1.
   - Follow-up identity operation → `overflow` returns to 0.
4. Handshake:
   - `start` held high → `done` pulses every 6 cycles.
   - `start` pulses during MAC and DONE → ignored.
   - Inputs changed the cycle after E0 → result unaffected.
5. Reset mid-operation: `reset` asserted 2 cycles after E0 → immediate `busy` = 0, no `done`, `vectorout` = [0,0]. A new `start` after release completes normally.
6. Parameter sweep: ROWS = 3, COLS = 4, FRAC = 0, random signed 8-bit-range data → matches a reference model; `done` at 12 cycles after E0.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and fixed-point helpers for the sequential matrix-vector multiplier.
// Rounding/saturation is written at a generic 128-bit width and sliced by callers.
package matmul_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_DONE} state_t;

  localparam int FX_MAXW = 128;

  typedef struct packed {
    logic [FX_MAXW-1:0] val;
    logic               ovf;
  } fx_res_t;

  function automatic int acc_width(input int width, input int cols);
    return 2 * width + $clog2(cols);
  endfunction

  // Round half up, arithmetic shift by frac, then clamp or wrap into width bits.
  function automatic fx_res_t fx_round_sat(input logic signed [FX_MAXW-1:0] acc,
                                           input int width, input int frac, input bit sat);
    logic signed [FX_MAXW-1:0] one;
    logic signed [FX_MAXW-1:0] rnd;
    logic signed [FX_MAXW-1:0] hi;
    logic signed [FX_MAXW-1:0] lo;
    fx_res_t res;
    one = {{(FX_MAXW-1){1'b0}}, 1'b1};
    rnd = acc;
    if (frac > 0) rnd = acc + (one <<< (frac - 1));
    rnd = rnd >>> frac;
    hi  = (one <<< (width - 1)) - one;
    lo  = -(one <<< (width - 1));
    res.ovf = (rnd > hi) || (rnd < lo);
    if (res.ovf && sat) res.val = (rnd > hi) ? hi : lo;
    else                res.val = rnd;
    return res;
  endfunction

endpackage

// File: rtl/fx_mac_unit.sv
// Signed multiply-accumulate with clear/enable; finalise output is combinational
// on acc + current product so the last term of a row is included in its result.
module fx_mac_unit
  import matmul_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int FRAC     = 8,
  parameter int COLS     = 2,
  parameter int SATURATE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_fin_dat,
  output logic             o_fin_ovf
);

  localparam int AW = acc_width(WIDTH, COLS);

  logic signed [AW-1:0]      r_acc;
  logic signed [2*WIDTH-1:0] w_prod;
  logic signed [AW-1:0]      w_sum;
  fx_res_t                   w_res;
  logic                      w_unused;

  assign w_prod    = (2*WIDTH)'($signed(i_a)) * (2*WIDTH)'($signed(i_b));
  assign w_sum     = r_acc + AW'(w_prod);
  assign w_res     = fx_round_sat(FX_MAXW'(w_sum), WIDTH, FRAC, SATURATE != 0);
  assign o_fin_dat = w_res.val[WIDTH-1:0];
  assign o_fin_ovf = w_res.ovf;
  assign w_unused  = ^w_res.val;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     r_acc <= '0;
    else if (i_clr) r_acc <= '0;
    else if (i_en)  r_acc <= w_sum;
  end

endmodule

// File: rtl/seq_matrix_multiplier.sv
// Sequential fixed-point matrix x vector: one MAC per clock, start/busy/done handshake,
// results and sticky overflow published together on the final MAC edge.
module seq_matrix_multiplier
  import matmul_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int FRAC     = 8,
  parameter int ROWS     = 2,
  parameter int COLS     = 2,
  parameter int SATURATE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] vectorin  [COLS],
  input  logic [WIDTH-1:0] matrixin  [ROWS][COLS],
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] vectorout [ROWS],
  output logic             overflow
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [RW-1:0] LAST_R = RW'(ROWS - 1);
  localparam logic [CW-1:0] LAST_C = CW'(COLS - 1);

  state_t           r_state;
  logic [RW-1:0]    r_row;
  logic [CW-1:0]    r_col;
  logic [WIDTH-1:0] r_vec   [COLS];
  logic [WIDTH-1:0] r_mat   [ROWS][COLS];
  logic [WIDTH-1:0] r_stage [ROWS];
  logic             r_ovf_int;

  logic             w_en;
  logic             w_clr;
  logic             w_last_col;
  logic             w_last_row;
  logic [WIDTH-1:0] w_fin_dat;
  logic             w_fin_ovf;

  assign w_en       = (r_state == ST_MAC);
  assign w_last_col = (r_col == LAST_C);
  assign w_last_row = (r_row == LAST_R);
  assign w_clr      = ((r_state == ST_IDLE) && start) || (w_en && w_last_col);

  fx_mac_unit #(
    .WIDTH(WIDTH), .FRAC(FRAC), .COLS(COLS), .SATURATE(SATURATE)
  ) u_mac (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (w_clr),
    .i_en      (w_en),
    .i_a       (r_mat[r_row][r_col]),
    .i_b       (r_vec[r_col]),
    .o_fin_dat (w_fin_dat),
    .o_fin_ovf (w_fin_ovf)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      r_ovf_int <= 1'b0;
      r_row     <= '0;
      r_col     <= '0;
      for (int c = 0; c < COLS; c++) r_vec[c] <= '0;
      for (int r = 0; r < ROWS; r++) begin
        r_stage[r]   <= '0;
        vectorout[r] <= '0;
        for (int c = 0; c < COLS; c++) r_mat[r][c] <= '0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_vec     <= vectorin;
            r_mat     <= matrixin;
            r_row     <= '0;
            r_col     <= '0;
            r_ovf_int <= 1'b0;
            busy      <= 1'b1;
            r_state   <= ST_MAC;
          end
        end
        ST_MAC: begin
          if (w_last_col) begin
            r_col          <= '0;
            r_stage[r_row] <= w_fin_dat;
            r_ovf_int      <= r_ovf_int | w_fin_ovf;
            if (w_last_row) begin
              // Staged rows and the row finishing now go out in the same edge.
              for (int r = 0; r < ROWS; r++)
                vectorout[r] <= (r == ROWS - 1) ? w_fin_dat : r_stage[r];
              overflow <= r_ovf_int | w_fin_ovf;
              busy     <= 1'b0;
              done     <= 1'b1;
              r_row    <= '0;
              r_state  <= ST_DONE;
            end else begin
              r_row <= r_row + 1'b1;
            end
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
        ST_DONE: begin
          done    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_matrix_multiplier.sv
// Bench: saturating and wrapping 2x2 Q24.8 instances share stimulus; a 3x4 FRAC=0 instance covers the sweep.
module tb_seq_matrix_multiplier;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 2x2 instances (saturate and wrap) driven identically
  logic        start;
  logic [31:0] vin [2];
  logic [31:0] min [2][2];
  logic        busy_s, done_s, ovf_s, busy_w, done_w, ovf_w;
  logic [31:0] vout_s [2];
  logic [31:0] vout_w [2];

  // 3x4 FRAC=0 instance
  logic        s_start;
  logic [31:0] s_vin [4];
  logic [31:0] s_min [3][4];
  logic        s_busy, s_done, s_ovf;
  logic [31:0] s_vout [3];

  int checks   = 0;
  int failures = 0;

  seq_matrix_multiplier u_sat (
    .clk(clk), .reset(reset), .start(start), .vectorin(vin), .matrixin(min),
    .busy(busy_s), .done(done_s), .vectorout(vout_s), .overflow(ovf_s));

  seq_matrix_multiplier #(.SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .start(start), .vectorin(vin), .matrixin(min),
    .busy(busy_w), .done(done_w), .vectorout(vout_w), .overflow(ovf_w));

  seq_matrix_multiplier #(.ROWS(3), .COLS(4), .FRAC(0)) u_sweep (
    .clk(clk), .reset(reset), .start(s_start), .vectorin(s_vin), .matrixin(s_min),
    .busy(s_busy), .done(s_done), .vectorout(s_vout), .overflow(s_ovf));

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Exact rational value sum / 2^frac, rounded to nearest with ties toward +inf.
  function automatic logic signed [127:0] fx_ref(input logic signed [127:0] sum, input int frac);
    logic signed [127:0] d, t, q;
    d = 128'sd1 <<< frac;
    t = sum + d / 2;
    q = t / d;
    if ((t % d) != 0 && t < 0) q = q - 1;
    return q;
  endfunction

  // {overflow, value} for a 32-bit output
  function automatic logic [32:0] fx_fin(input logic signed [127:0] q, input bit sat);
    logic signed [127:0] mx, mn;
    mx = 128'sd2147483647;
    mn = -128'sd2147483648;
    if (q > mx) return {1'b1, sat ? 32'h7FFF_FFFF : q[31:0]};
    if (q < mn) return {1'b1, sat ? 32'h8000_0000 : q[31:0]};
    return {1'b0, q[31:0]};
  endfunction

  function automatic logic [31:0] rnd_elem();
    if ($urandom_range(0, 3) == 0) return $urandom;
    return 32'($urandom_range(0, 131072)) - 32'd65536;
  endfunction

  // One 2x2 operation with the currently driven inputs; inputs are scrambled right after E0.
  task automatic op_def(input string tag);
    logic [31:0] m [2][2];
    logic [31:0] v [2];
    logic [32:0] es [2];
    logic [32:0] ew [2];
    logic signed [127:0] s;
    int dcyc, ndone, ndone_w, nbusy;
    logic eo_s, eo_w;
    m = min; v = vin;
    eo_s = 1'b0; eo_w = 1'b0;
    for (int r = 0; r < 2; r++) begin
      s = 0;
      for (int c = 0; c < 2; c++) s += $signed(m[r][c]) * $signed(v[c]);
      es[r] = fx_fin(fx_ref(s, 8), 1'b1);
      ew[r] = fx_fin(fx_ref(s, 8), 1'b0);
      eo_s |= es[r][32];
      eo_w |= ew[r][32];
    end
    dcyc = -1; ndone = 0; ndone_w = 0; nbusy = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    for (int r = 0; r < 2; r++) begin
      vin[r] = $urandom;
      for (int c = 0; c < 2; c++) min[r][c] = $urandom;
    end
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      if (busy_s) nbusy++;
      if (done_s) begin ndone++; dcyc = k; end
      if (done_w) ndone_w++;
    end
    check_val({tag, ".latency"}, 64'(dcyc), 64'd4);
    check_val({tag, ".ndone"}, 64'(ndone), 64'd1);
    check_val({tag, ".ndone_w"}, 64'(ndone_w), 64'd1);
    check_val({tag, ".busy_cyc"}, 64'(nbusy), 64'd4);
    for (int r = 0; r < 2; r++) begin
      check_val($sformatf("%s.sat.v%0d", tag, r), 64'(vout_s[r]), 64'(es[r][31:0]));
      check_val($sformatf("%s.wrap.v%0d", tag, r), 64'(vout_w[r]), 64'(ew[r][31:0]));
    end
    check_val({tag, ".sat.ovf"}, 64'(ovf_s), 64'(eo_s));
    check_val({tag, ".wrap.ovf"}, 64'(ovf_w), 64'(eo_w));
  endtask

  task automatic op_sweep(input string tag);
    logic [31:0] m [3][4];
    logic [31:0] v [4];
    logic [32:0] e [3];
    logic signed [127:0] s;
    int dcyc, ndone;
    logic eo;
    m = s_min; v = s_vin; eo = 1'b0;
    for (int r = 0; r < 3; r++) begin
      s = 0;
      for (int c = 0; c < 4; c++) s += $signed(m[r][c]) * $signed(v[c]);
      e[r] = fx_fin(fx_ref(s, 0), 1'b1);
      eo |= e[r][32];
    end
    dcyc = -1; ndone = 0;
    @(negedge clk) s_start = 1'b1;
    @(posedge clk);
    @(negedge clk) s_start = 1'b0;
    for (int c = 0; c < 4; c++) s_vin[c] = $urandom;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      if (s_done) begin ndone++; dcyc = k; end
    end
    check_val({tag, ".latency"}, 64'(dcyc), 64'd12);
    check_val({tag, ".ndone"}, 64'(ndone), 64'd1);
    for (int r = 0; r < 3; r++)
      check_val($sformatf("%s.v%0d", tag, r), 64'(s_vout[r]), 64'(e[r][31:0]));
    check_val({tag, ".ovf"}, 64'(s_ovf), 64'(eo));
  endtask

  task automatic set_identity();
    min = '{'{32'd256, 32'd0}, '{32'd0, 32'd256}};
    vin = '{32'd768, 32'hFFFF_FE00};
  endtask

  initial begin
    int nd, t0, t1, t2;
    reset = 1'b1; start = 1'b0; s_start = 1'b0;
    vin = '{32'd0, 32'd0};
    min = '{'{32'd0, 32'd0}, '{32'd0, 32'd0}};
    for (int c = 0; c < 4; c++) s_vin[c] = '0;
    for (int r = 0; r < 3; r++) for (int c = 0; c < 4; c++) s_min[r][c] = '0;
    repeat (3) @(negedge clk);
    check_val("rst.busy", 64'(busy_s), 64'd0);
    check_val("rst.done", 64'(done_s), 64'd0);
    check_val("rst.ovf", 64'(ovf_s), 64'd0);
    check_val("rst.v0", 64'(vout_s[0]), 64'd0);
    check_val("rst.v1", 64'(vout_s[1]), 64'd0);
    check_val("rst.sweep_v2", 64'(s_vout[2]), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    set_identity();
    op_def("ident");
    check_val("ident.const0", 64'(vout_s[0]), 64'd768);
    check_val("ident.const1", 64'(vout_s[1]), 64'hFFFF_FE00);

    min = '{'{32'd128, 32'd0}, '{32'hFFFF_FF80, 32'd0}};
    vin = '{32'd1, 32'd0};
    op_def("round");
    check_val("round.const0", 64'(vout_s[0]), 64'd1);
    check_val("round.const1", 64'(vout_s[1]), 64'd0);

    min = '{'{32'h4000_0000, 32'h4000_0000}, '{32'hC000_0000, 32'hC000_0000}};
    vin = '{32'h0001_0000, 32'h0001_0000};
    op_def("satur");
    check_val("satur.const0", 64'(vout_s[0]), 64'h7FFF_FFFF);
    check_val("satur.const1", 64'(vout_s[1]), 64'h8000_0000);
    check_val("satur.const_ovf", 64'(ovf_s), 64'd1);
    check_val("wrap.const0", 64'(vout_w[0]), 64'd0);
    check_val("wrap.const_ovf", 64'(ovf_w), 64'd1);

    set_identity();
    op_def("ident2");
    check_val("ident2.ovf_clear", 64'(ovf_s), 64'd0);

    // Start pulses landing in MAC (sampled at E2) and DONE (sampled at E5) are dropped.
    set_identity();
    nd = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      start = (k == 1 || k == 4);
      if (done_s) nd++;
    end
    start = 1'b0;
    check_val("ignore.ndone", 64'(nd), 64'd1);
    check_val("ignore.v1", 64'(vout_s[1]), 64'hFFFF_FE00);

    // Held start repeats every ROWS*COLS+2 cycles.
    t0 = -1; t1 = -1; t2 = -1;
    @(negedge clk) start = 1'b1;
    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      if (done_s) begin
        if (t0 < 0) t0 = k; else if (t1 < 0) t1 = k; else if (t2 < 0) t2 = k;
      end
    end
    start = 1'b0;
    repeat (8) @(negedge clk);
    check_val("held.gap1", 64'(t1 - t0), 64'd6);
    check_val("held.gap2", 64'(t2 - t1), 64'd6);

    // Reset two cycles into an operation aborts it.
    set_identity();
    nd = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    @(negedge clk) reset = 1'b1;
    #1;
    check_val("abort.busy", 64'(busy_s), 64'd0);
    check_val("abort.v0", 64'(vout_s[0]), 64'd0);
    @(negedge clk) reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done_s) nd++;
    end
    check_val("abort.ndone", 64'(nd), 64'd0);
    check_val("abort.v1", 64'(vout_s[1]), 64'd0);
    check_val("abort.ovf", 64'(ovf_s), 64'd0);

    for (int i = 0; i < 12; i++) begin
      for (int r = 0; r < 2; r++) begin
        vin[r] = rnd_elem();
        for (int c = 0; c < 2; c++) min[r][c] = rnd_elem();
      end
      op_def($sformatf("rnd%0d", i));
    end

    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < 4; c++) s_vin[c] = 32'($urandom_range(0, 255)) - 32'd128;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 4; c++) s_min[r][c] = 32'($urandom_range(0, 255)) - 32'd128;
      op_sweep($sformatf("sweep%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
